// File: rtl/pe_sched_pkg.sv
// Shared state type and default sizing for the PE array scheduler.
package pe_sched_pkg;

   localparam int PIPE_DEPTH_DEF = 4;
   localparam int CNT_WIDTH_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/pe_sched_token_pipe.sv
// Valid/last token shadow of the PE datapath: stage 0 loads on the load strobe,
// later stages advance only when the previous cycle carried a load.
module pe_sched_token_pipe
   import pe_sched_pkg::*;
#(
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_tok_vld,
   input  logic i_tok_last,
   output logic o_vld,
   output logic o_last
);

   logic                  r_ld_q;
   logic [PIPE_DEPTH-1:0] r_tok;
   logic [PIPE_DEPTH-1:0] r_lst;
   logic                  r_vld;
   logic                  r_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ld_q <= 1'b0;
         r_tok  <= '0;
         r_lst  <= '0;
         r_vld  <= 1'b0;
         r_last <= 1'b0;
      end else begin
         r_ld_q <= i_load;
         if (i_load) begin
            r_tok[0] <= i_tok_vld;
            r_lst[0] <= i_tok_last;
         end
         if (r_ld_q) begin
            for (int i = 1; i < PIPE_DEPTH; i++) begin
               r_tok[i] <= r_tok[i-1];
               r_lst[i] <= r_lst[i-1];
            end
         end
         // The output stage is consumed by the same advance, so a token fires once.
         r_vld  <= r_ld_q & r_tok[PIPE_DEPTH-1];
         r_last <= r_ld_q & r_tok[PIPE_DEPTH-1] & r_lst[PIPE_DEPTH-1];
      end
   end

   assign o_vld  = r_vld;
   assign o_last = r_last;

endmodule

// File: rtl/pe_arr_sched.sv
// Job sequencer for the 9-tap PE array: window loads, pipeline flush, OFM stream.
// Define PE_SCHED_PERF_EN to add the saturating perf_cycles/perf_stalls counters.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | consuming one window per accepted win_valid
// FLUSH | PIPE_DEPTH-1 dummy loads push the last result out
// DONE  | one cycle; done pulses in the following cycle
module pe_arr_sched
   import pe_sched_pkg::*;
#(
   parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
   parameter int OUTPUT_WIDTH = 32,
   parameter int PIPE_DEPTH   = PIPE_DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_WIDTH-1:0]    cfg_num_pix,
   input  logic                    win_valid,
   output logic                    win_ready,
   output logic                    ready_load,
   input  logic [OUTPUT_WIDTH-1:0] ofm_output,
   output logic                    ofm_valid,
   output logic [OUTPUT_WIDTH-1:0] ofm_data,
   output logic                    ofm_last,
   output logic                    busy,
   output logic                    done
`ifdef PE_SCHED_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]    perf_cycles,
   output logic [CNT_WIDTH-1:0]    perf_stalls
`endif
);

   localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] C_FLUSH_LD = CNT_WIDTH'(PIPE_DEPTH - 2);

   sched_state_e         r_state;
   sched_state_e         w_state_nxt;
   logic [CNT_WIDTH-1:0] r_num_pix;
   logic [CNT_WIDTH-1:0] r_pix_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;
   logic                 r_done;
   logic                 w_accept;
   logic                 w_final;
   logic                 w_start_ok;
   logic                 w_flush_tc;

   assign w_start_ok = (r_state == IDLE) & start;
   assign w_flush_tc = (r_flush_cnt == '0);

   always_comb begin
      w_state_nxt = r_state;
      win_ready   = 1'b0;
      ready_load  = 1'b0;
      w_accept    = 1'b0;
      w_final     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_state_nxt = (cfg_num_pix == '0) ? DONE : RUN;
         end
         RUN: begin
            win_ready  = 1'b1;
            w_accept   = win_valid;
            ready_load = win_valid;
            w_final    = win_valid & (r_pix_cnt == r_num_pix - C_ONE);
            if (w_final) w_state_nxt = (PIPE_DEPTH > 1) ? FLUSH : DONE;
         end
         FLUSH: begin
            ready_load = 1'b1;
            if (w_flush_tc) w_state_nxt = DONE;
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_num_pix   <= '0;
         r_pix_cnt   <= '0;
         r_flush_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == DONE);
         if (w_start_ok) begin
            r_num_pix <= cfg_num_pix;
            r_pix_cnt <= '0;
         end else if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + C_ONE;
         end
         // Down-counter loaded on the final accept; FLUSH ends at terminal count.
         if (w_final) begin
            r_flush_cnt <= C_FLUSH_LD;
         end else if ((r_state == FLUSH) && !w_flush_tc) begin
            r_flush_cnt <= r_flush_cnt - C_ONE;
         end
      end
   end

   pe_sched_token_pipe #(
      .PIPE_DEPTH (PIPE_DEPTH)
   ) u_token_pipe (
      .clk        (clk),
      .rst        (rst),
      .i_load     (ready_load),
      .i_tok_vld  (w_accept),
      .i_tok_last (w_final),
      .o_vld      (ofm_valid),
      .o_last     (ofm_last)
   );

   assign ofm_data = ofm_valid ? ofm_output : '0;
   assign busy     = (r_state != IDLE);
   assign done     = r_done;

`ifdef PE_SCHED_PERF_EN
   logic [CNT_WIDTH-1:0] r_perf_cycles;
   logic [CNT_WIDTH-1:0] r_perf_stalls;

   always_ff @(posedge clk) begin
      if (rst || w_start_ok) begin
         r_perf_cycles <= '0;
         r_perf_stalls <= '0;
      end else begin
         if (busy && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + C_ONE;
         if ((r_state == RUN) && !win_valid && (r_perf_stalls != '1))
            r_perf_stalls <= r_perf_stalls + C_ONE;
      end
   end

   assign perf_cycles = r_perf_cycles;
   assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_pe_arr_sched.sv
// Directed bench for pe_arr_sched: cycle-stamped event log checked against hand-derived offsets.
module tb_pe_arr_sched;

   localparam int CW = 16;
   localparam int OW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] cfg_num_pix;
   logic          win_valid;
   logic          win_ready;
   logic          ready_load;
   logic [OW-1:0] ofm_output;
   logic          ofm_valid;
   logic [OW-1:0] ofm_data;
   logic          ofm_last;
   logic          busy;
   logic          done;
`ifdef PE_SCHED_PERF_EN
   logic [CW-1:0] perf_cycles;
   logic [CW-1:0] perf_stalls;
`endif

   pe_arr_sched #(.CNT_WIDTH(CW), .OUTPUT_WIDTH(OW), .PIPE_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cfg_num_pix (cfg_num_pix),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .ready_load  (ready_load),
      .ofm_output  (ofm_output),
      .ofm_valid   (ofm_valid),
      .ofm_data    (ofm_data),
      .ofm_last    (ofm_last),
      .busy        (busy),
      .done        (done)
`ifdef PE_SCHED_PERF_EN
      ,
      .perf_cycles (perf_cycles),
      .perf_stalls (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            q_vld[$];
   int            q_last[$];
   int            q_done[$];
   logic [OW-1:0] q_data[$];
   int            n_load = 0;
   int            n_wrdy = 0;
   int            n_leak = 0;

   always @(negedge clk) begin
      if (ofm_valid) begin
         q_vld.push_back(cyc);
         q_data.push_back(ofm_data);
      end
      if (ofm_last) q_last.push_back(cyc);
      if (done) q_done.push_back(cyc);
      if (ready_load) n_load++;
      if (win_ready) n_wrdy++;
      if (!ofm_valid && (ofm_data != '0)) n_leak++;
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int qget(input int q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return -1;
   endfunction

   function automatic logic [OW-1:0] qgetd(input logic [OW-1:0] q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return '1;
   endfunction

   int b_v, b_l, b_d, b_ld, b_wr;

   task automatic mark();
      b_v  = q_vld.size();
      b_l  = q_last.size();
      b_d  = q_done.size();
      b_ld = n_load;
      b_wr = n_wrdy;
   endtask

   // nv results on consecutive cycles starting t0+first; done expected at t0+done_off
   task automatic check_job(input string tag, input int t0, input int nv, input int first,
                            input int done_off, input int loads, input int wrdy,
                            input logic [OW-1:0] data);
      chk_eq({tag, "_nvld"}, q_vld.size() - b_v, nv);
      for (int i = 0; i < nv; i++) begin
         chk_eq($sformatf("%s_vld%0d_cyc", tag, i), qget(q_vld, b_v + i), t0 + first + i);
         chk_eq($sformatf("%s_vld%0d_data", tag, i), qgetd(q_data, b_v + i), data);
      end
      chk_eq({tag, "_nlast"}, q_last.size() - b_l, (nv > 0) ? 1 : 0);
      if (nv > 0) chk_eq({tag, "_last_cyc"}, qget(q_last, b_l), t0 + first + nv - 1);
      chk_eq({tag, "_ndone"}, q_done.size() - b_d, 1);
      chk_eq({tag, "_done_cyc"}, qget(q_done, b_d), t0 + done_off);
      chk_eq({tag, "_loads"}, n_load - b_ld, loads);
      chk_eq({tag, "_wready"}, n_wrdy - b_wr, wrdy);
   endtask

   int t0;

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      cfg_num_pix = '0;
      win_valid   = 1'b0;
      ofm_output  = 32'h0000_0009;
      step(2);
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_win_ready", win_ready, 1'b0);
      chk_eq("rst_ready_load", ready_load, 1'b0);
      chk_eq("rst_ofm_valid", ofm_valid, 1'b0);
      chk_eq("rst_ofm_last", ofm_last, 1'b0);
      chk_eq("rst_done", done, 1'b0);
      chk_eq("rst_ofm_data", ofm_data, 32'h0);
      rst = 1'b0;
      step(2);

      // 3 pixels back to back; win_valid stays high through flush/done
      mark();
      ofm_output = 32'hA5A5_0003;
      t0 = cyc; start = 1'b1; cfg_num_pix = 16'd3; win_valid = 1'b1;
      step(1); start = 1'b0;
      step(8); win_valid = 1'b0;
      step(4);
      check_job("t1", t0, 3, 6, 8, 6, 3, 32'hA5A5_0003);

      // 2 pixels with a 2-cycle window gap; all-ones taps give 9
      mark();
      ofm_output = 32'h0000_0009;
      t0 = cyc; start = 1'b1; cfg_num_pix = 16'd2; win_valid = 1'b1;
      step(1); start = 1'b0;
      step(1); win_valid = 1'b0;
      step(2); win_valid = 1'b1;
      step(1); win_valid = 1'b0;
      step(8);
      check_job("t2", t0, 2, 8, 9, 5, 4, 32'h0000_0009);

      // empty job
      mark();
      t0 = cyc; start = 1'b1; cfg_num_pix = 16'd0; win_valid = 1'b1;
      step(1); start = 1'b0;
      step(5); win_valid = 1'b0;
      step(2);
      check_job("t3", t0, 0, 0, 2, 0, 0, 32'h0);

      // second start mid-job is ignored
      mark();
      ofm_output = 32'h0001_2345;
      t0 = cyc; start = 1'b1; cfg_num_pix = 16'd3; win_valid = 1'b1;
      step(1); start = 1'b0;
      step(1); start = 1'b1; cfg_num_pix = 16'd5;
      step(1); start = 1'b0;
      step(6); win_valid = 1'b0;
      step(6);
      check_job("t4", t0, 3, 6, 8, 6, 3, 32'h0001_2345);

      // reset during FLUSH aborts silently
      mark();
      t0 = cyc; start = 1'b1; cfg_num_pix = 16'd1; win_valid = 1'b1;
      step(1); start = 1'b0;
      step(1); win_valid = 1'b0;
      step(1); rst = 1'b1;
      step(1); rst = 1'b0;
      chk_eq("t5_busy", busy, 1'b0);
      chk_eq("t5_ready_load", ready_load, 1'b0);
      chk_eq("t5_win_ready", win_ready, 1'b0);
      chk_eq("t5_ofm_valid", ofm_valid, 1'b0);
      chk_eq("t5_done", done, 1'b0);
      step(10);
      chk_eq("t5_no_done", q_done.size() - b_d, 0);
      chk_eq("t5_no_vld", q_vld.size() - b_v, 0);

      mark();
      ofm_output = 32'h0000_0777;
      t0 = cyc; start = 1'b1; cfg_num_pix = 16'd1; win_valid = 1'b1;
      step(1); start = 1'b0;
      step(1); win_valid = 1'b0;
      step(8);
      check_job("t5b", t0, 1, 6, 6, 4, 1, 32'h0000_0777);

`ifdef PE_SCHED_PERF_EN
      // 4 pixels with 3 stall cycles: 7 RUN + 3 FLUSH + 1 DONE busy cycles
      mark();
      t0 = cyc; start = 1'b1; cfg_num_pix = 16'd4; win_valid = 1'b1;
      step(1); start = 1'b0;
      step(1); win_valid = 1'b0;
      step(3); win_valid = 1'b1;
      step(3); win_valid = 1'b0;
      step(6);
      chk_eq("perf_done_cyc", qget(q_done, b_d), t0 + 12);
      chk_eq("perf_stalls", perf_stalls, 16'd3);
      chk_eq("perf_cycles", perf_cycles, 16'd11);
      step(4);
      chk_eq("perf_cycles_hold", perf_cycles, 16'd11);
`endif

      chk_eq("data_leak", n_leak, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_arr_sched.md
Name: pe_arr_sched

Overview:
Sequencer for the 9-tap PE array / adder-tree datapath. It runs a job of N output pixels. For each pixel it accepts one window (ifm taps, weights and bias held stable by the upstream window buffer) and pulses ready_load. It tracks in-flight results through the datapath's stall-on-idle pipeline and flushes the pipeline at job end. It emits a valid/last-tagged OFM stream toward the activation stage.

Parameters:
CNT_WIDTH, 16, width of pixel count and job counters
OUTPUT_WIDTH, 32, OFM word width (matches PE array output)
PIPE_DEPTH, 4, datapath advancing stages between a load and a valid ofm (PE stage + 4 tree levels, first level is the load-qualified one)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle job start; ignored while busy
cfg_num_pix  in  CNT_WIDTH  pixels in job; sampled on accepted start
win_valid  in  1  window buffer presents a complete window
win_ready  out  1  window consumed this cycle
ready_load  out  1  drives PE array load strobe
ofm_output  in  OUTPUT_WIDTH  saturated sum from PE array
ofm_valid  out  1  ofm_data holds a real pixel result
ofm_data  out  OUTPUT_WIDTH  result word
ofm_last  out  1  qualifies final pixel of job (with ofm_valid)
busy  out  1  job in progress (state != IDLE)
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset (rst=1 at posedge): state IDLE; win_ready, ready_load, ofm_valid, ofm_last, busy, done = 0; ofm_data = 0; counters and tokens cleared. Mid-job reset aborts immediately with no done pulse. The top level asserts datapath reset in the same cycle.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 latches cfg_num_pix and goes to RUN. If cfg_num_pix=0, go to DONE instead; no loads are issued.
- RUN: win_ready=1 (combinational from state). Accept = win_valid & win_ready, and ready_load = accept.
  - Each accept increments pix_cnt. On the accept where pix_cnt == num_pix-1, go to FLUSH.
  - win_valid=0 gaps are legal. The datapath holds, and tokens hold.
- FLUSH: ready_load=1, win_ready=0 for exactly PIPE_DEPTH-1 cycles. These are dummy loads that carry invalid tokens. Then go to DONE.
- DONE: one cycle, then IDLE. done=1 is registered and coincides with the ofm_valid&ofm_last cycle. For an empty job, done is the only activity.
- Token pipe mirrors the datapath advance rule:
  - ld_q = ready_load delayed one cycle.
  - tok[0]/lastbit[0] load {accept, accept & final} on any ready_load cycle, and hold otherwise.
  - tok[i], i = 1..PIPE_DEPTH-1, shift from tok[i-1] only when ld_q=1.
- ofm_valid: registered, set on an edge where ld_q & tok[PIPE_DEPTH-1], cleared otherwise. Never two cycles for one token.
- Latency: with ready_load high on edges k..k+3, a window accepted at edge k yields ofm_valid in the cycle after edge k+4.
- ofm_data = ofm_output while ofm_valid, else 0. ofm_last = ofm_valid & last token bit.
- busy=1 in RUN/FLUSH/DONE.
- Simultaneous events: start during busy is ignored. win_valid in FLUSH/DONE/IDLE is not consumed.
- pix_cnt does not wrap; the max job is 2^CNT_WIDTH-1 pixels.

Optional Feature:
PE_SCHED_PERF_EN: adds outputs perf_cycles and perf_stalls, both CNT_WIDTH wide and saturating.
- perf_cycles counts busy cycles; perf_stalls counts RUN cycles with win_valid=0.
- Both clear on accepted start and on rst, and hold after done.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package pe_sched_pkg: state enum typedef (IDLE/RUN/FLUSH/DONE), PIPE_DEPTH_DEF=4, CNT_WIDTH_DEF=16.
- One sub-module, pe_sched_token_pipe: the valid/last token shift register with the ld_q advance rule. This isolates the datapath-timing model for reuse by a future multi-array scheduler.

Test Plan:
- num_pix=3, win_valid held 1: 3 accepts on consecutive cycles, then 3 flush cycles with ready_load=1. ofm_valid for 3 consecutive cycles, the first 5 cycles after the first accept cycle. ofm_last and done on the third.
- num_pix=2 with win_valid low for 2 cycles between windows: both results valid, each exactly once. The gap delays the second result by 2 cycles, and ofm_data matches the golden sums (e.g. all taps 1×1, bias 0 -> 9).
- num_pix=0: start -> done pulse 2 cycles later. ready_load, win_ready and ofm_valid stay 0.
- start pulsed again mid-job: ignored. Pixel count and done timing are unchanged.
- rst asserted during FLUSH: next cycle all outputs 0 and state IDLE, with no done. A new job of 1 pixel then completes normally.
- PE_SCHED_PERF_EN: num_pix=4 with 3 stall cycles -> perf_stalls=3, and perf_cycles = busy cycle count (4+3+3+1=11).
